sha256_block_padder: RTL

Upstream feeder for the SHA-256 compression core. It reads a message of `num_words` 32-bit words from word-addressed memory and appends standard SHA-256 padding: a single 1 bit, zeros, and a 64-bit bit-length. It then presents the result as a sequence of 512-bit blocks over a valid/ready handshake. The block owns all memory reads and all padding arithmetic, so the compression core only has to consume complete blocks.

---
 rtl/sha256_block_padder_if.sv | 19 +
 rtl/sha256_block_padder.sv | 110 +++++++++++
 2 files changed

// File: rtl/sha256_block_padder_if.sv
// sha256_block_padder_if: memory read port and 512-bit block stream of the SHA-256 padder.
interface sha256_block_padder_if;
  logic mem_rd;
  logic [15:0] mem_addr;
  logic [31:0] mem_read_data;
  logic blk_valid;
  logic blk_ready;
  logic [511:0] blk_data;
  logic blk_first;
  logic blk_last;
  modport master (
    output mem_rd, mem_addr, blk_valid, blk_data, blk_first, blk_last,
    input  mem_read_data, blk_ready
  );
  modport slave (
    input  mem_rd, mem_addr, blk_valid, blk_data, blk_first, blk_last,
    output mem_read_data, blk_ready
  );
endinterface

// File: rtl/sha256_block_padder.sv
// sha256_block_padder: fetches a message from word memory and emits SHA-256 padded 512-bit blocks.
// Define SHA256_PADDER_BSWAP_EN to byte-reverse every fetched word (little-endian memory).
module sha256_block_padder (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic [15:0] message_addr,
  input  logic [15:0] num_words,
  output logic busy,
  output logic done,
  sha256_block_padder_if.master bus
);
  typedef enum logic [1:0] {IDLE, FETCH, PAD, EMIT} state_t;
  state_t state;
  logic [15:0] ptr, rem, len, src_ptr, src_rem;
  logic [4:0] iss, cap;
  logic cap_en, marked, first, fin, go, has_words;
  logic [15:0][31:0] words, padded;
  logic [31:0] din;
`ifdef SHA256_PADDER_BSWAP_EN
  assign din = {bus.mem_read_data[7:0], bus.mem_read_data[15:8], bus.mem_read_data[23:16], bus.mem_read_data[31:24]};
`else
  assign din = bus.mem_read_data;
`endif
  assign bus.blk_data = words;
  assign go = (state == IDLE && start) || (state == EMIT && bus.blk_valid && bus.blk_ready && !bus.blk_last);
  assign src_ptr = state == IDLE ? message_addr : ptr;
  assign src_rem = state == IDLE ? num_words : rem;
  assign has_words = src_rem != 16'd0;
  // length fits only when slots 14 and 15 are still free after the marker
  assign fin = marked || cap <= 5'd13;
  for (genvar g = 0; g < 16; g++) begin : gen_pad
    assign padded[15-g] = 5'(g) < cap ? words[15-g] :
                          (5'(g) == cap && !marked) ? 32'h8000_0000 :
                          (g == 15 && fin) ? {11'd0, len, 5'd0} : 32'd0;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      ptr <= '0;
      rem <= '0;
      len <= '0;
      iss <= '0;
      cap <= '0;
      cap_en <= 1'b0;
      marked <= 1'b0;
      first <= 1'b0;
      words <= '0;
      bus.mem_rd <= 1'b0;
      bus.mem_addr <= '0;
      bus.blk_valid <= 1'b0;
      bus.blk_first <= 1'b0;
      bus.blk_last <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      cap_en <= bus.mem_rd;
      if (cap_en) begin
        words[~cap[3:0]] <= din;
        cap <= cap + 5'd1;
      end
      if (state == IDLE && start) begin
        busy <= 1'b1;
        len <= num_words;
        marked <= 1'b0;
        first <= 1'b1;
      end
      // each block launch issues its first read on the same edge it leaves IDLE/EMIT
      if (go) begin
        state <= has_words ? FETCH : PAD;
        bus.mem_rd <= has_words;
        bus.mem_addr <= src_ptr;
        ptr <= src_ptr + 16'd1;
        rem <= src_rem - {15'd0, has_words};
        iss <= src_rem > 16'd15 ? 5'd15 : 5'(src_rem - 16'd1);
        cap <= '0;
      end
      if (state == FETCH) begin
        bus.mem_rd <= iss != 5'd0;
        if (iss != 5'd0) begin
          bus.mem_addr <= ptr;
          ptr <= ptr + 16'd1;
          rem <= rem - 16'd1;
          iss <= iss - 5'd1;
        end
        if (cap_en && !bus.mem_rd) state <= PAD;
      end
      if (state == PAD) begin
        words <= padded;
        marked <= marked | ~cap[4];
        first <= 1'b0;
        bus.blk_valid <= 1'b1;
        bus.blk_first <= first;
        bus.blk_last <= fin;
        state <= EMIT;
      end
      if (state == EMIT && bus.blk_valid && bus.blk_ready) begin
        bus.blk_valid <= 1'b0;
        bus.blk_first <= 1'b0;
        bus.blk_last <= 1'b0;
        if (bus.blk_last) begin
          state <= IDLE;
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end
endmodule
